priority_encoder_sync: RTL and testbench



---
 rtl/float_conv_pkg.sv | 10 +
 rtl/lzc_cell.sv | 44 ++++
 rtl/priority_encoder_sync.sv | 43 ++++
 tb/tb_priority_encoder_sync.sv | 101 ++++++++++
 4 files changed

// File: rtl/float_conv_pkg.sv
// Shared widths and types for the twos-to-float conversion path.
package float_conv_pkg;

    localparam int unsigned MAG_W   = 11;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_SAT = 8;

    typedef logic [CNT_W-1:0] lz_cnt_t;

endpackage

// File: rtl/lzc_cell.sv
// Leading-zero count of a 2**LOG_W-bit slice, built recursively from 2-bit leaves.
// cnt is only meaningful when all_zero is low.
module lzc_cell #(
    parameter int unsigned LOG_W = 1
) (
    input  logic [(1 << LOG_W)-1:0] data,
    output logic [LOG_W-1:0]        cnt,
    output logic                    all_zero
);

    generate
        if (LOG_W == 1) begin : g_leaf
            always_comb begin
                all_zero = ~(data[1] | data[0]);
                cnt      = ~data[1];
            end
        end else begin : g_node
            localparam int unsigned HALF_W = 1 << (LOG_W - 1);

            logic [LOG_W-2:0] cnt_hi;
            logic [LOG_W-2:0] cnt_lo;
            logic             zero_hi;
            logic             zero_lo;

            lzc_cell #(.LOG_W(LOG_W - 1)) u_hi (
                .data     (data[2*HALF_W-1:HALF_W]),
                .cnt      (cnt_hi),
                .all_zero (zero_hi)
            );

            lzc_cell #(.LOG_W(LOG_W - 1)) u_lo (
                .data     (data[HALF_W-1:0]),
                .cnt      (cnt_lo),
                .all_zero (zero_lo)
            );

            always_comb begin
                all_zero = zero_hi & zero_lo;
                cnt      = zero_hi ? {1'b1, cnt_lo} : {1'b0, cnt_hi};
            end
        end
    endgenerate

endmodule

// File: rtl/priority_encoder_sync.sv
// Registered leading-zero count of {1'b0, in}, saturated at 8, with an all-zero flag.
module priority_encoder_sync
    import float_conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [MAG_W-1:0] in,
    output logic             out_valid,
    output lz_cnt_t          out,
    output logic             zero
);

    logic [2:0] lz8;
    logic       top_zero;
    lz_cnt_t    next_cnt;

    // Saturation at 8 means only the top 8 bits of the 12-bit word matter.
    lzc_cell #(.LOG_W(3)) u_lzc (
        .data     ({1'b0, in[MAG_W-1:4]}),
        .cnt      (lz8),
        .all_zero (top_zero)
    );

    always_comb begin
        next_cnt = top_zero ? lz_cnt_t'(CNT_SAT) : {1'b0, lz8};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= lz_cnt_t'(CNT_SAT);
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= next_cnt;
                zero <= ~|in;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_sync.sv
// Directed bench for priority_encoder_sync: reset, walking one, saturation, hold, reset priority, sweep.
module tb_priority_encoder_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [10:0] in;
    logic        out_valid;
    logic [3:0]  out;
    logic        zero;

    int unsigned passed = 0;
    int unsigned total  = 0;

    priority_encoder_sync dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
        .out_valid (out_valid),
        .out       (out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_out,
                             input logic e_zero, input logic e_valid);
        check({tag, ".out"},       {1'b0, out},   {1'b0, e_out});
        check({tag, ".zero"},      {4'b0, zero},  {4'b0, e_zero});
        check({tag, ".out_valid"}, {4'b0, out_valid}, {4'b0, e_valid});
    endtask

    function automatic logic [3:0] ref_count(input logic [10:0] v);
        for (int i = 10; i >= 0; i--) begin
            if (v[i]) return (11 - i > 8) ? 4'd8 : 4'(11 - i);
        end
        return 4'd8;
    endfunction

    logic [3:0] walk_exp [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in = '0;
        tick(); tick();
        check_all("reset", 4'd8, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        check_all("release_idle", 4'd8, 1'b1, 1'b0);

        in_valid = 1'b1; in = 11'h400;
        tick();
        check_all("msb", 4'd1, 1'b0, 1'b1);
        in = 11'h7FF;
        tick();
        check_all("all_ones", 4'd1, 1'b0, 1'b1);

        for (int k = 10; k >= 0; k--) begin
            in = 11'(1) << k;
            tick();
            check_all($sformatf("walk%0d", k), walk_exp[10-k], 1'b0, 1'b1);
        end

        in = 11'h00F; tick(); check_all("h00F", 4'd8, 1'b0, 1'b1);
        in = 11'h000; tick(); check_all("h000", 4'd8, 1'b1, 1'b1);
        in = 11'h010; tick(); check_all("h010", 4'd7, 1'b0, 1'b1);

        in = 11'h080; tick(); check_all("h080", 4'd4, 1'b0, 1'b1);
        in_valid = 1'b0; in = 11'h001;
        tick(); check_all("hold", 4'd4, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in = 11'h400;
        tick(); check_all("rst_prio", 4'd8, 1'b1, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        tick(); check_all("post_rst_idle", 4'd8, 1'b1, 1'b0);
        in_valid = 1'b1; in = 11'h200;
        tick(); check_all("post_rst_first", 4'd2, 1'b0, 1'b1);

        for (int v = 0; v < 2048; v++) begin
            in = 11'(v);
            tick();
            check($sformatf("sweep%0d.out", v), {1'b0, out}, {1'b0, ref_count(11'(v))});
            check($sformatf("sweep%0d.zero", v), {4'b0, zero}, {4'b0, (v == 0)});
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
